// File: rtl/time_keeper.sv
// MM:SS time-keeping core: counts on a 1 Hz enable, pauses on a debounced button,
// and lets the user step minutes or seconds while in adjust mode.
module time_keeper #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sec_tick,
   input  logic        adj_tick,
   input  logic        adj_sw,
   input  logic        sel_sw,
   input  logic        pause_btn,
   output logic [15:0] digits,
   output logic        adj_out,
   output logic [1:0]  state_dbg
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      ADJUST = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          btn_level_q;
   logic [CW-1:0] deb_cnt_q;
   logic          pause_evt;
   logic [7:0]    sec_q, min_q;
   logic [8:0]    sec_inc, min_inc;

   // Returns {carry, tens, ones} for a 00..59 BCD field stepped by one.
   function automatic logic [8:0] inc59(input logic [7:0] fld);
      logic [3:0] tens, ones;
      tens = fld[7:4];
      ones = fld[3:0];
      if (ones == 4'd9) begin
         if (tens == 4'd5) inc59 = {1'b1, 8'h00};
         else              inc59 = {1'b0, tens + 4'd1, 4'd0};
      end else begin
         inc59 = {1'b0, tens, ones + 4'd1};
      end
   endfunction

   // Two-flop synchronizer, then a counter that must see the new level
   // persist for DEBOUNCE_CYCLES cycles before it is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         btn_level_q <= 1'b0;
         deb_cnt_q   <= '0;
         pause_evt   <= 1'b0;
      end else begin
         sync1_q   <= pause_btn;
         sync2_q   <= sync1_q;
         pause_evt <= 1'b0;
         if (sync2_q == btn_level_q) begin
            deb_cnt_q <= '0;
         end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q   <= '0;
            btn_level_q <= sync2_q;
            pause_evt   <= sync2_q;
         end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (adj_sw)         state_d = ADJUST;
            else if (pause_evt) state_d = PAUSED;
         end
         PAUSED: begin
            if (adj_sw)         state_d = ADJUST;
            else if (pause_evt) state_d = RUN;
         end
         ADJUST: begin
            if (!adj_sw)        state_d = PAUSED;
         end
         default:               state_d = PAUSED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PAUSED;
         adj_out <= 1'b0;
      end else begin
         state_q <= state_d;
         adj_out <= (state_d == ADJUST);
      end
   end

   assign sec_inc = inc59(sec_q);
   assign min_inc = inc59(min_q);

   // Ticks act on the state held during the cycle, so a tick that coincides
   // with a transition out of RUN or ADJUST is still applied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_q <= 8'h00;
         min_q <= 8'h00;
      end else if (state_q == RUN && sec_tick) begin
         sec_q <= sec_inc[7:0];
         if (sec_inc[8]) min_q <= min_inc[7:0];
      end else if (state_q == ADJUST && adj_tick) begin
         if (sel_sw) sec_q <= sec_inc[7:0];
         else        min_q <= min_inc[7:0];
      end
   end

   assign digits    = {min_q, sec_q};
   assign state_dbg = state_q;

endmodule
